rst_seq: RTL and testbench



---
 rtl/rst_seq_if.sv | 24 ++
 rtl/rst_seq.sv | 149 ++++++++++++++
 tb/tb_rst_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Sequenced-reset bundle: soft-reset request, per-stage acks and the sequenced
// reset/status outputs. master = sequencer side, slave = consumer side.
interface rst_seq_if #(
  parameter int P_STAGES = 4
) ();
  localparam int SW = $clog2(P_STAGES + 1);

  logic                i_soft_rst;
  logic [P_STAGES-1:0] i_ack;
  logic [P_STAGES-1:0] o_rst;
  logic [SW-1:0]       o_stage;
  logic                o_done;
  logic                o_timeout_err;

  modport master (
    input  i_soft_rst, i_ack,
    output o_rst, o_stage, o_done, o_timeout_err
  );

  modport slave (
    output i_soft_rst, i_ack,
    input  o_rst, o_stage, o_done, o_timeout_err
  );
endinterface

// File: rtl/rst_seq.sv
// Releases P_STAGES reset domains in index order, waiting for each ack, with a
// per-stage timeout. Optional auto re-sequence on ack loss: RST_SEQ_ACK_LOSS_EN.
module rst_seq #(
  parameter int P_STAGES     = 4,
  parameter int P_HOLD_CYCLE = 16,
  parameter int P_TIMEOUT    = 1024,
  parameter int P_CNT_W      = 16
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rst_seq_if.master bus
);
  localparam int SW = $clog2(P_STAGES + 1);
  localparam logic [P_CNT_W-1:0] HOLD_LAST = P_CNT_W'(P_HOLD_CYCLE - 1);
  localparam logic [P_CNT_W-1:0] TO_LAST   = P_CNT_W'(P_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [P_CNT_W-1:0]  cnt_q, cnt_d;
  logic [P_STAGES-1:0] rst_q, rst_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ack_k;
`ifdef RST_SEQ_ACK_LOSS_EN
  logic [P_STAGES-1:0] released;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '1;
      stage_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    stage_d = stage_q;
    done_d  = done_q;
    err_d   = err_q;
    ack_k   = 1'b0;
`ifdef RST_SEQ_ACK_LOSS_EN
    released = '0;
`endif

    // Mux by loop so the index width never depends on P_STAGES vs SW.
    for (int unsigned k = 0; k < P_STAGES; k++) begin
      if (k == 32'(stage_q)) ack_k = bus.i_ack[k];
`ifdef RST_SEQ_ACK_LOSS_EN
      if (k < 32'(stage_q)) released[k] = 1'b1;
`endif
    end

    case (state_q)
      S_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          stage_d  = '0;
          state_d  = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + P_CNT_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (ack_k) begin
          if (stage_q == SW'(P_STAGES - 1)) begin
            done_d  = 1'b1;
            stage_d = SW'(P_STAGES);
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_GAP;
          end
        end else if (P_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          rst_d   = '1;
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + P_CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == HOLD_LAST) begin
          stage_d = stage_q + SW'(1);
          for (int unsigned k = 0; k < P_STAGES; k++) begin
            if (k == 32'(stage_q) + 1) rst_d[k] = 1'b0;
          end
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + P_CNT_W'(1);
        end
      end
      S_DONE:  ;
      S_ERROR: begin
        rst_d = '1;
        err_d = 1'b1;
      end
      default: state_d = S_ASSERT;
    endcase

`ifdef RST_SEQ_ACK_LOSS_EN
    // In DONE stage_q == P_STAGES, so every stage counts as released.
    if ((state_q == S_WAIT_ACK || state_q == S_GAP || state_q == S_DONE) &&
        |(released & ~bus.i_ack)) begin
      rst_d   = '1;
      done_d  = 1'b0;
      cnt_d   = '0;
      stage_d = '0;
      state_d = S_ASSERT;
    end
`endif

    if (bus.i_soft_rst) begin
      rst_d   = '1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      stage_d = '0;
      cnt_d   = '0;
      state_d = S_ASSERT;
    end
  end

  assign bus.o_rst         = rst_q;
  assign bus.o_stage       = stage_q;
  assign bus.o_done        = done_q;
  assign bus.o_timeout_err = err_q;
endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with P_STAGES=3, P_HOLD_CYCLE=4, P_TIMEOUT=8.
module tb_rst_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rst_seq_if #(.P_STAGES(3)) bus ();

  rst_seq #(
    .P_STAGES    (3),
    .P_HOLD_CYCLE(4),
    .P_TIMEOUT   (8),
    .P_CNT_W     (16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_rst, input int e_stage,
                         input int e_done, input int e_err);
    chk({tag, ".rst"},   32'(bus.o_rst),         32'(e_rst));
    chk({tag, ".stage"}, 32'(bus.o_stage),       32'(e_stage));
    chk({tag, ".done"},  32'(bus.o_done),        32'(e_done));
    chk({tag, ".err"},   32'(bus.o_timeout_err), 32'(e_err));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_soft_rst = 1'b0;
    bus.i_ack = 3'b000;
    tick(3);
    chk_all("reset", 7, 0, 0, 0);

    // Normal sequence
    rst = 1'b0;
    tick(3);
    chk_all("hold3", 7, 0, 0, 0);
    tick(1);
    chk_all("rel0", 6, 0, 0, 0);
    tick(2);
    bus.i_ack = 3'b001;
    tick(1);
    chk_all("gap0_entry", 6, 0, 0, 0);
    tick(3);
    chk_all("gap0_end", 6, 0, 0, 0);
    tick(1);
    chk_all("rel1", 4, 1, 0, 0);
    tick(2);
    bus.i_ack = 3'b011;
    tick(5);
    chk_all("rel2", 0, 2, 0, 0);
    tick(2);
    bus.i_ack = 3'b111;
    tick(1);
    chk_all("done", 0, 3, 1, 0);
    tick(10);
    chk_all("done_hold", 0, 3, 1, 0);

    // Ack loss in DONE
    bus.i_ack = 3'b110;
    tick(1);
    bus.i_ack = 3'b111;
`ifdef RST_SEQ_ACK_LOSS_EN
    chk_all("ackloss", 7, 0, 0, 0);
`else
    chk_all("ackloss", 0, 3, 1, 0);
`endif
    tick(20);
    chk_all("ackloss_settle", 0, 3, 1, 0);

    // Soft reset from DONE
    bus.i_soft_rst = 1'b1;
    bus.i_ack = 3'b000;
    tick(1);
    bus.i_soft_rst = 1'b0;
    chk_all("soft_done", 7, 0, 0, 0);
    tick(3);
    chk_all("soft_done_hold", 7, 0, 0, 0);
    tick(1);
    chk_all("soft_done_rel0", 6, 0, 0, 0);

    // Ack arriving on the timeout edge wins
    tick(7);
    chk_all("bnd_pre", 6, 0, 0, 0);
    bus.i_ack = 3'b001;
    tick(1);
    chk_all("bnd_edge", 6, 0, 0, 0);
    tick(3);
    chk_all("bnd_gap", 6, 0, 0, 0);
    tick(1);
    chk_all("bnd_rel1", 4, 1, 0, 0);

    // Timeout on stage 1
    tick(7);
    chk_all("to_pre", 4, 1, 0, 0);
    tick(1);
    chk_all("to_hit", 7, 1, 0, 1);
    tick(50);
    chk_all("to_hold", 7, 1, 0, 1);

    // Soft reset from ERROR
    bus.i_soft_rst = 1'b1;
    bus.i_ack = 3'b000;
    tick(1);
    bus.i_soft_rst = 1'b0;
    chk_all("soft_err", 7, 0, 0, 0);
    tick(3);
    chk_all("soft_err_hold", 7, 0, 0, 0);
    tick(1);
    chk_all("soft_err_rel0", 6, 0, 0, 0);

    // i_rst in the middle of GAP
    bus.i_ack = 3'b001;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk_all("midrst", 7, 0, 0, 0);
    tick(2);
    rst = 1'b0;
    bus.i_ack = 3'b000;
    tick(3);
    chk_all("midrst_hold", 7, 0, 0, 0);
    tick(1);
    chk_all("midrst_rel0", 6, 0, 0, 0);
    bus.i_ack = 3'b111;
    tick(5);
    chk_all("midrst_rel1", 4, 1, 0, 0);
    tick(5);
    chk_all("midrst_rel2", 0, 2, 0, 0);
    tick(1);
    chk_all("midrst_done", 0, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
